// File: rtl/pe_result_drain_if.sv
// Result stream from the drain to downstream map inflation: value, occupancy
// bit and end-of-line marker under a valid/ready handshake.
interface pe_result_drain_if #(
    parameter int OUT_WIDTH = 8
);
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_occ;
    logic                 out_last;
    logic                 out_valid;
    logic                 out_ready;

    modport master (
        output out_data, out_occ, out_last, out_valid,
        input  out_ready
    );

    modport slave (
        input  out_data, out_occ, out_last, out_valid,
        output out_ready
    );
endinterface

// File: rtl/pe_result_drain.sv
// Reduces PE-array row sums to one result, scales/saturates/thresholds it,
// buffers it in a FWFT FIFO and streams it out, stalling the array before overflow.
module pe_result_drain #(
    parameter int KERNEL_SIZE  = 3,
    parameter int DATA_WIDTH   = 8,
    parameter int WEIGHT_WIDTH = 8,
    parameter int OUT_WIDTH    = 8,
    parameter int SHIFT        = 0,
    parameter int FIFO_DEPTH   = 16,
    parameter int SKID         = 6,
    parameter int LINE_WIDTH   = 64,
    localparam int SUM_WIDTH   = DATA_WIDTH + WEIGHT_WIDTH + KERNEL_SIZE,
    localparam int ACC_WIDTH   = SUM_WIDTH + $clog2(KERNEL_SIZE),
    localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic [SUM_WIDTH*KERNEL_SIZE-1:0] sum_in,
    input  logic                             sum_valid,
    input  logic [ACC_WIDTH-1:0]             threshold,
    input  logic                             clear_ovf,
    pe_result_drain_if.master                out_if,
    output logic                             stall,
    output logic                             overflow,
    output logic [LVL_W-1:0]                 fifo_level
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
    localparam int ENT_W = OUT_WIDTH + 1;

    logic [ACC_WIDTH-1:0] row_total;
    logic [ACC_WIDTH-1:0] s1_total;
    logic [ACC_WIDTH-1:0] scaled;
    logic [OUT_WIDTH-1:0] sat_val;
    logic                 s1_valid;
    logic                 s2_valid;
    logic [OUT_WIDTH-1:0] s2_val;
    logic                 s2_occ;

    logic [ENT_W-1:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [COL_W-1:0]     col;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic                 drop;

    always_comb begin
        row_total = '0;
        for (int r = 0; r < KERNEL_SIZE; r++) begin
            row_total = row_total + ACC_WIDTH'(sum_in[r*SUM_WIDTH +: SUM_WIDTH]);
        end
    end

    assign scaled  = s1_total >> SHIFT;
    assign sat_val = (|scaled[ACC_WIDTH-1:OUT_WIDTH]) ? '1 : scaled[OUT_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid <= 1'b0;
            s1_total <= '0;
            s2_valid <= 1'b0;
            s2_val   <= '0;
            s2_occ   <= 1'b0;
        end else begin
            s1_valid <= sum_valid;
            if (sum_valid) begin
                s1_total <= row_total;
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_val <= sat_val;
                s2_occ <= (s1_total >= threshold);
            end
        end
    end

    assign full  = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign empty = (fifo_level == '0);
    assign pop   = !empty && out_if.out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign push  = s2_valid && (!full || pop);
    assign drop  = s2_valid && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s2_val, s2_occ};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            overflow   <= 1'b0;
            stall      <= 1'b0;
            col        <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
                col    <= (col == COL_W'(LINE_WIDTH - 1)) ? '0 : col + COL_W'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + LVL_W'(1);
                2'b01:   fifo_level <= fifo_level - LVL_W'(1);
                default: fifo_level <= fifo_level;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (clear_ovf) begin
                overflow <= 1'b0;
            end
            stall <= (fifo_level >= LVL_W'(FIFO_DEPTH - SKID));
        end
    end

    always_comb begin
        out_if.out_data = '0;
        out_if.out_occ  = 1'b0;
        if (!empty) begin
            {out_if.out_data, out_if.out_occ} = mem[rd_ptr];
        end
    end

    assign out_if.out_valid = !empty;
    assign out_if.out_last  = !empty && (col == COL_W'(LINE_WIDTH - 1));
endmodule

// File: tb/tb_pe_result_drain.sv
// Bench for pe_result_drain: directed scenarios plus randomized traffic checked
// against an in-order queue of results computed from the arithmetic rules.
module tb_pe_result_drain;
    localparam int KS  = 3;
    localparam int SW  = 19;
    localparam int AW  = 21;
    localparam int OW  = 8;
    localparam int LW  = 4;
    localparam int LVL = 5;

    logic           clk = 1'b0;
    logic           rstn = 1'b0;
    logic [SW*KS-1:0] sum_in = '0;
    logic           sum_valid = 1'b0;
    logic [AW-1:0]  threshold = AW'(50);
    logic           clear_ovf = 1'b0;
    logic           stall, overflow, stall_b, overflow_b;
    logic [LVL-1:0] fifo_level, fifo_level_b;

    pe_result_drain_if #(.OUT_WIDTH(OW)) sif ();
    pe_result_drain_if #(.OUT_WIDTH(OW)) sif_b ();

    always #5 clk = ~clk;

    pe_result_drain #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_WIDTH(OW),
                      .SHIFT(0), .FIFO_DEPTH(16), .SKID(6), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rstn(rstn), .sum_in(sum_in), .sum_valid(sum_valid),
        .threshold(threshold), .clear_ovf(clear_ovf), .out_if(sif.master),
        .stall(stall), .overflow(overflow), .fifo_level(fifo_level));

    pe_result_drain #(.KERNEL_SIZE(3), .DATA_WIDTH(8), .WEIGHT_WIDTH(8), .OUT_WIDTH(OW),
                      .SHIFT(1), .FIFO_DEPTH(16), .SKID(6), .LINE_WIDTH(LW)) dut_b (
        .clk(clk), .rstn(rstn), .sum_in(sum_in), .sum_valid(sum_valid),
        .threshold(threshold), .clear_ovf(clear_ovf), .out_if(sif_b.master),
        .stall(stall_b), .overflow(overflow_b), .fifo_level(fifo_level_b));

    initial sif_b.out_ready = 1'b1;

    int         tests = 0;
    int         fails = 0;
    logic [8:0] exp_q[$];
    int         col_m = 0;
    logic       p, l;
    logic [8:0] g;

    // Expected {value, occupancy} from the arithmetic rules.
    function automatic logic [8:0] model(int a, int b, int c, int thr, int sh);
        int t, s;
        logic [7:0] v;
        t = a + b + c;
        s = t >> sh;
        v = (s > 255) ? 8'hFF : 8'(s);
        return {v, (t >= thr)};
    endfunction

    // Drive one cycle at a falling edge; report whether a transfer happens at the next rising edge.
    task automatic cyc(input logic sv, input int a, input int b, input int c, input logic rdy,
                       output logic popped, output logic [8:0] got, output logic lst);
        sum_in        = {SW'(c), SW'(b), SW'(a)};
        sum_valid     = sv;
        sif.out_ready = rdy;
        if (sv) exp_q.push_back(model(a, b, c, int'(threshold), 0));
        popped = sif.out_valid && rdy;
        got    = {sif.out_data, sif.out_occ};
        lst    = sif.out_last;
        @(negedge clk);
    endtask

    // Single result through an empty pipeline with out_ready held high.
    task automatic shot(input int a, input int b, input int c, output logic v2, output logic v3,
                        output logic [8:0] obs3, output logic [7:0] obs_b, output logic popped);
        logic [8:0] gg;
        logic       ll;
        cyc(1'b1, a, b, c, 1'b1, popped, gg, ll);
        cyc(1'b0, 0, 0, 0, 1'b1, popped, gg, ll);
        v2 = sif.out_valid;
        cyc(1'b0, 0, 0, 0, 1'b1, popped, gg, ll);
        v3    = sif.out_valid;
        obs3  = {sif.out_data, sif.out_occ};
        obs_b = sif_b.out_data;
        cyc(1'b0, 0, 0, 0, 1'b1, popped, gg, ll);
        exp_q.delete();
        if (popped) col_m = (col_m + 1) % LW;
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests++; if (sif.out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b want 0", sif.out_valid); end
        tests++; if (sif.out_last !== 1'b0) begin fails++; $display("FAIL reset_last got %b want 0", sif.out_last); end
        tests++; if ({sif.out_data, sif.out_occ} !== 9'h0) begin fails++; $display("FAIL reset_data got %h want 0", {sif.out_data, sif.out_occ}); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL reset_stall got %b want 0", stall); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL reset_ovf got %b want 0", overflow); end
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        rstn = 1'b1;
        exp_q.delete();
        col_m = 0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic v2, v3, pp;
        logic [8:0] o3;
        logic [7:0] ob;
        threshold = AW'(50);
        shot(10, 20, 30, v2, v3, o3, ob, pp);
        tests++; if (v2 !== 1'b0) begin fails++; $display("FAIL lat_early got %b want 0", v2); end
        tests++; if (v3 !== 1'b1) begin fails++; $display("FAIL lat_valid got %b want 1", v3); end
        tests++; if (o3 !== model(10, 20, 30, 50, 0)) begin fails++; $display("FAIL lat_data got %h want %h", o3, model(10, 20, 30, 50, 0)); end
        tests++; if (o3[8:1] !== 8'd60) begin fails++; $display("FAIL lat_value got %0d want 60", o3[8:1]); end
        tests++; if (pp !== 1'b1) begin fails++; $display("FAIL lat_pop got %b want 1", pp); end
    endtask

    task automatic test_saturate();
        logic v2, v3, pp;
        logic [8:0] o3;
        logic [7:0] ob;
        logic [8:0] eb;
        threshold = AW'(50);
        eb = model(200, 100, 5, 50, 1);
        shot(200, 100, 5, v2, v3, o3, ob, pp);
        tests++; if (o3 !== model(200, 100, 5, 50, 0)) begin fails++; $display("FAIL sat_data got %h want %h", o3, model(200, 100, 5, 50, 0)); end
        tests++; if (ob !== eb[8:1]) begin fails++; $display("FAIL shift1_data got %0d want %0d", ob, eb[8:1]); end
    endtask

    task automatic test_threshold();
        int thr_tab[3] = '{50, 6, 7};
        logic v2, v3, pp;
        logic [8:0] o3;
        logic [7:0] ob;
        for (int k = 0; k < 3; k++) begin
            threshold = AW'(thr_tab[k]);
            shot(1, 2, 3, v2, v3, o3, ob, pp);
            tests++;
            if (o3 !== model(1, 2, 3, thr_tab[k], 0)) begin
                fails++; $display("FAIL thr_%0d got %h want %h", thr_tab[k], o3, model(1, 2, 3, thr_tab[k], 0));
            end
        end
        threshold = AW'(50);
    endtask

    task automatic test_overflow();
        int c10 = -1;
        int npop = 0;
        logic [8:0] e;
        for (int i = 0; i < 21; i++) begin
            if (i < 17) cyc(1'b1, int'($urandom_range(0, 100)), int'($urandom_range(0, 100)), int'($urandom_range(0, 100)), 1'b0, p, g, l);
            else        cyc(1'b0, 0, 0, 0, 1'b0, p, g, l);
            if (c10 < 0 && fifo_level == 5'd10) begin
                c10 = i;
                tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_early got %b want 0", stall); end
            end else if (c10 >= 0 && i == c10 + 1) begin
                tests++; if (stall !== 1'b1) begin fails++; $display("FAIL stall_rise got %b want 1", stall); end
            end
        end
        tests++; if (c10 < 0) begin fails++; $display("FAIL stall_level10 got never want level 10"); end
        void'(exp_q.pop_back());
        tests++; if (fifo_level !== 5'd16) begin fails++; $display("FAIL ovf_level got %0d want 16", fifo_level); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_set got %b want 1", overflow); end
        for (int i = 0; i < 24; i++) begin
            cyc(1'b0, 0, 0, 0, 1'b1, p, g, l);
            if (p) begin
                npop++;
                if (exp_q.size() == 0) begin
                    tests++; fails++; $display("FAIL ovf_extra_pop got %h want none", g);
                end else begin
                    e = exp_q.pop_front();
                    tests++; if (g !== e) begin fails++; $display("FAIL ovf_order got %h want %h", g, e); end
                    tests++; if (l !== 1'(col_m == LW - 1)) begin fails++; $display("FAIL ovf_last got %b want %b", l, col_m == LW - 1); end
                    col_m = (col_m + 1) % LW;
                end
            end
        end
        tests++; if (npop != 16) begin fails++; $display("FAIL ovf_count got %0d want 16", npop); end
        tests++; if (overflow !== 1'b1) begin fails++; $display("FAIL ovf_sticky got %b want 1", overflow); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL stall_fall got %b want 0", stall); end
        clear_ovf = 1'b1;
        cyc(1'b0, 0, 0, 0, 1'b1, p, g, l);
        clear_ovf = 1'b0;
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear got %b want 0", overflow); end
    endtask

    task automatic test_last();
        int k = 0;
        logic [8:0] e;
        rstn = 1'b0; sum_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b1; exp_q.delete(); col_m = 0;
        for (int i = 0; i < 80 && !(k == 8 && i >= 8); i++) begin
            if (i < 8) cyc(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'(i % 2), p, g, l);
            else       cyc(1'b0, 0, 0, 0, 1'(i % 2), p, g, l);
            if (p && exp_q.size() > 0) begin
                k++;
                e = exp_q.pop_front();
                tests++; if (g !== e) begin fails++; $display("FAIL last_data got %h want %h", g, e); end
                tests++; if (l !== 1'(k % 4 == 0)) begin fails++; $display("FAIL last_flag xfer %0d got %b want %b", k, l, k % 4 == 0); end
                col_m = k % LW;
            end
        end
        tests++; if (k != 8) begin fails++; $display("FAIL last_count got %0d want 8", k); end
    endtask

    task automatic test_random();
        int issued = 0;
        int npop = 0;
        logic sv, rdy;
        logic [8:0] e;
        threshold = AW'($urandom_range(0, 600));
        for (int i = 0; i < 3000 && npop < 60; i++) begin
            sv  = (issued < 60) && !stall && ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 3) != 0);
            cyc(sv, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), rdy, p, g, l);
            if (sv) issued++;
            if (p) begin
                npop++;
                if (exp_q.size() == 0) begin
                    tests++; fails++; $display("FAIL rand_extra_pop got %h want none", g);
                end else begin
                    e = exp_q.pop_front();
                    tests++; if (g !== e) begin fails++; $display("FAIL rand_data got %h want %h", g, e); end
                    tests++; if (l !== 1'(col_m == LW - 1)) begin fails++; $display("FAIL rand_last got %b want %b", l, col_m == LW - 1); end
                    col_m = (col_m + 1) % LW;
                end
            end
        end
        tests++; if (npop != 60) begin fails++; $display("FAIL rand_count got %0d want 60", npop); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL rand_ovf got %b want 0", overflow); end
        threshold = AW'(50);
    endtask

    task automatic test_reset_midop();
        int k = 0;
        logic [8:0] e;
        for (int i = 0; i < 7; i++)
            cyc(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b0, p, g, l);
        tests++; if (fifo_level !== 5'd5) begin fails++; $display("FAIL mid_prefill got %0d want 5", fifo_level); end
        sum_valid = 1'b0; rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1; exp_q.delete(); col_m = 0;
        tests++; if (sif.out_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got %b want 0", sif.out_valid); end
        tests++; if (fifo_level !== 5'd0) begin fails++; $display("FAIL mid_level got %0d want 0", fifo_level); end
        tests++; if (stall !== 1'b0) begin fails++; $display("FAIL mid_stall got %b want 0", stall); end
        tests++; if (overflow !== 1'b0) begin fails++; $display("FAIL mid_ovf got %b want 0", overflow); end
        for (int i = 0; i < 4; i++) cyc(1'b0, 0, 0, 0, 1'b0, p, g, l);
        tests++; if (sif.out_valid !== 1'b0 || fifo_level !== 5'd0) begin
            fails++; $display("FAIL mid_inflight got valid %b level %0d want 0 0", sif.out_valid, fifo_level);
        end
        for (int i = 0; i < 12; i++) begin
            if (i < 4) cyc(1'b1, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 1'b1, p, g, l);
            else       cyc(1'b0, 0, 0, 0, 1'b1, p, g, l);
            if (p && exp_q.size() > 0) begin
                k++;
                e = exp_q.pop_front();
                tests++; if (g !== e) begin fails++; $display("FAIL mid_data got %h want %h", g, e); end
                tests++; if (l !== 1'(k == 4)) begin fails++; $display("FAIL mid_col xfer %0d got %b want %b", k, l, k == 4); end
            end
        end
        tests++; if (k != 4) begin fails++; $display("FAIL mid_count got %0d want 4", k); end
    endtask

    initial begin
        sif.out_ready = 1'b0;
        test_reset();
        test_latency();
        test_saturate();
        test_threshold();
        test_overflow();
        test_last();
        test_random();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
